// File: rtl/hs_fifo_responder.sv
// Responder end of the req/ack handshake: upstream pushes fill a FIFO, and a downstream
// requester drains it one word per ack, with at most one ack every two cycles.
module hs_fifo_responder #(
   parameter  int data_width = 32,
   parameter  int depth      = 8,
   localparam int aw         = $clog2(depth)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [data_width-1:0] wr_data,
   output logic                  full,
   input  logic                  stall,
   input  logic                  req,
   output logic                  ack,
   output logic [data_width-1:0] dout,
   output logic [aw:0]           level,
   output logic                  overflow
);

   typedef enum logic {S_IDLE, S_ACK} state_t;

   state_t                state_reg;
   logic [data_width-1:0] mem [depth];
   logic [aw-1:0]         wr_ptr_reg;
   logic [aw-1:0]         rd_ptr_reg;
   logic [aw:0]           level_reg;
   logic                  ack_reg;
   logic                  overflow_reg;
   logic [data_width-1:0] dout_reg;

   logic is_full;
   logic push;
   logic pop;

   // full comes from the pre-edge occupancy, so a pop in the same cycle never frees a slot for a push
   assign is_full = (level_reg == (aw+1)'(depth));
   assign push    = wr_en & ~is_full;
   assign pop     = (state_reg == S_IDLE) & req & ~stall & (level_reg != '0);

   // Storage has no reset; a push during the reset cycle is simply not written
   always_ff @(posedge clk) begin
      if (rst && push)
         mem[wr_ptr_reg] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         ack_reg      <= 1'b0;
         overflow_reg <= 1'b0;
         dout_reg     <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + aw'(1);
         if (wr_en && is_full)
            overflow_reg <= 1'b1;

         case (state_reg)
            S_IDLE: begin
               if (pop) begin
                  ack_reg    <= 1'b1;
                  dout_reg   <= mem[rd_ptr_reg];
                  rd_ptr_reg <= rd_ptr_reg + aw'(1);
                  state_reg  <= S_ACK;
               end else begin
                  ack_reg <= 1'b0;
               end
            end
            S_ACK: begin
               ack_reg   <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: begin
               ack_reg   <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase

         case ({push, pop})
            2'b10:   level_reg <= level_reg + (aw+1)'(1);
            2'b01:   level_reg <= level_reg - (aw+1)'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   assign full     = is_full;
   assign ack      = ack_reg;
   assign dout     = dout_reg;
   assign level    = level_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_hs_fifo_responder.sv
// Directed bench for hs_fifo_responder: a queue-based model checked every cycle, plus
// hand-computed expectations for each scenario.
module tb_hs_fifo_responder;

   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic          stall;
   logic          req;
   logic          ack;
   logic [DW-1:0] dout;
   logic [3:0]    level;
   logic          overflow;

   hs_fifo_responder #(.data_width(DW), .depth(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
      .stall(stall), .req(req), .ack(ack), .dout(dout), .level(level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Model: contents as a queue; an ack may only follow a cycle without one
   logic [DW-1:0] mq[$];
   logic          m_ack;
   logic          m_ovf;
   logic [DW-1:0] m_dout;
   int            n_chk  = 0;
   int            n_fail = 0;
   bit            chk_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int  pre_size;
      bit  do_pop;
      if (!rst) begin
         mq.delete();
         m_ack  = 1'b0;
         m_dout = '0;
         m_ovf  = 1'b0;
      end else begin
         pre_size = mq.size();
         do_pop   = req && !stall && !m_ack && pre_size > 0;
         if (do_pop)
            m_dout = mq.pop_front();
         m_ack = do_pop;
         if (wr_en) begin
            if (pre_size == DEPTH)
               m_ovf = 1'b1;
            else
               mq.push_back(wr_data);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ack", 32'(ack), 32'(m_ack));
         chk("dout", dout, m_dout);
         chk("level", 32'(level), 32'(mq.size()));
         chk("full", 32'(full), 32'(mq.size() == DEPTH));
         chk("overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   logic [DW-1:0] got[$];
   int            b2b;
   logic          prev_ack;
   int            n_ack;

   task automatic record();
      if (ack) begin
         if (prev_ack)
            b2b++;
         got.push_back(dout);
      end
      prev_ack = ack;
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b1; wr_data = 32'hDEAD; stall = 1'b0; req = 1'b1;

      // T1: reset with req and wr_en asserted
      tick();
      chk_en = 1;
      tick();
      chk("t1_ack", 32'(ack), 32'd0);
      chk("t1_level", 32'(level), 32'd0);
      chk("t1_overflow", 32'(overflow), 32'd0);
      chk("t1_dout", dout, 32'd0);
      wr_en = 1'b0;
      rst   = 1'b1;
      tick();
      chk("t1_no_ack_after", 32'(ack), 32'd0);

      // T2: stream 1..8 with req held
      got.delete(); b2b = 0; prev_ack = 1'b0;
      req = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         wr_en = 1'b1; wr_data = 32'(i);
         tick(); record();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(); record();
      end
      chk("t2_count", 32'(got.size()), 32'd8);
      for (int i = 0; i < got.size() && i < 8; i++)
         chk("t2_data", got[i], 32'(i + 1));
      chk("t2_back_to_back", 32'(b2b), 32'd0);
      chk("t2_level_end", 32'(level), 32'd0);
      chk("t2_ack_end", 32'(ack), 32'd0);

      // T3: first word into an empty FIFO is acked one edge after it lands
      wr_en = 1'b1; wr_data = 32'hA5;
      tick();
      chk("t3_no_early_ack", 32'(ack), 32'd0);
      wr_en = 1'b0;
      tick();
      chk("t3_ack", 32'(ack), 32'd1);
      chk("t3_dout", dout, 32'hA5);
      tick();
      chk("t3_ack_drop", 32'(ack), 32'd0);

      // T4: overfill without req, then drain
      req = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         wr_en = 1'b1; wr_data = 32'h40 + 32'(i);
         tick();
         if (i == 8) begin
            chk("t4_full", 32'(full), 32'd1);
            chk("t4_no_ovf_yet", 32'(overflow), 32'd0);
         end
      end
      chk("t4_overflow", 32'(overflow), 32'd1);
      chk("t4_level", 32'(level), 32'd8);
      wr_en = 1'b0; req = 1'b1;
      got.delete(); b2b = 0; prev_ack = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(); record();
      end
      chk("t4_count", 32'(got.size()), 32'd8);
      for (int i = 0; i < got.size() && i < 8; i++)
         chk("t4_data", got[i], 32'h41 + 32'(i));

      // T5: stall holds off acks; then push every cycle while draining
      req = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         wr_en = 1'b1; wr_data = 32'h50 + 32'(i);
         tick();
      end
      wr_en = 1'b0; stall = 1'b1; req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_stall_no_ack", 32'(ack), 32'd0);
      end
      chk("t5_level_held", 32'(level), 32'd3);
      stall = 1'b0; n_ack = 0;
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = 32'h60 + 32'(i);
         tick();
         if (ack) n_ack++;
      end
      chk("t5_ack_count", 32'(n_ack), 32'd3);
      chk("t5_level", 32'(level), 32'd6);
      chk("t5_ovf_sticky", 32'(overflow), 32'd1);

      // T6: reset right after an ack with level 4
      wr_en = 1'b0; req = 1'b0; rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         wr_en = 1'b1; wr_data = 32'h70 + 32'(i);
         tick();
      end
      wr_en = 1'b0; req = 1'b1;
      tick();
      chk("t6_ack_pre", 32'(ack), 32'd1);
      chk("t6_level_pre", 32'(level), 32'd4);
      rst = 1'b0; wr_en = 1'b1; wr_data = 32'hEE;
      tick();
      chk("t6_ack_rst", 32'(ack), 32'd0);
      chk("t6_level_rst", 32'(level), 32'd0);
      chk("t6_ovf_rst", 32'(overflow), 32'd0);
      rst = 1'b1; req = 1'b0; wr_data = 32'h7;
      tick();
      wr_en = 1'b0; req = 1'b1;
      n_ack = 0;
      for (int i = 0; i < 6 && n_ack == 0; i++) begin
         tick();
         if (ack) n_ack++;
      end
      chk("t6_ack_seen", 32'(n_ack), 32'd1);
      chk("t6_dout", dout, 32'h7);
      req = 1'b0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
